// File: rtl/avalon_arb_pkg.sv
// Shared types and constants for the two-master Avalon-MM RAM arbiter.
package avalon_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic M_CPU  = 1'b0;
  localparam logic M_LOAD = 1'b1;

  localparam logic [1:0] GRANT_IDLE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // One-hot owner vector for a given arbiter state.
  function automatic logic [1:0] grant_of(input arb_state_t s);
    case (s)
      OWN0:    grant_of = GRANT_M0;
      OWN1:    grant_of = GRANT_M1;
      default: grant_of = GRANT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/avalon_port_mux.sv
// Combinational select of one master's command signals onto the slave port.
// An idle grant drives all command signals to zero.
module avalon_port_mux
  import avalon_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned BE_W  = DATA_W / 8
) (
  input  logic [1:0]        i_grant,
  input  logic [ADDR_W-1:0] i_m0_address,
  input  logic              i_m0_read,
  input  logic              i_m0_write,
  input  logic [DATA_W-1:0] i_m0_writedata,
  input  logic [BE_W-1:0]   i_m0_byteenable,
  input  logic [ADDR_W-1:0] i_m1_address,
  input  logic              i_m1_read,
  input  logic              i_m1_write,
  input  logic [DATA_W-1:0] i_m1_writedata,
  input  logic [BE_W-1:0]   i_m1_byteenable,
  output logic [ADDR_W-1:0] o_address_c,
  output logic              o_read_c,
  output logic              o_write_c,
  output logic [DATA_W-1:0] o_writedata_c,
  output logic [BE_W-1:0]   o_byteenable_c
);

  always_comb begin
    o_address_c    = '0;
    o_read_c       = 1'b0;
    o_write_c      = 1'b0;
    o_writedata_c  = '0;
    o_byteenable_c = '0;
    case (i_grant)
      GRANT_M0: begin
        o_address_c    = i_m0_address;
        o_read_c       = i_m0_read;
        o_write_c      = i_m0_write;
        o_writedata_c  = i_m0_writedata;
        o_byteenable_c = i_m0_byteenable;
      end
      GRANT_M1: begin
        o_address_c    = i_m1_address;
        o_read_c       = i_m1_read;
        o_write_c      = i_m1_write;
        o_writedata_c  = i_m1_writedata;
        o_byteenable_c = i_m1_byteenable;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Two-master (CPU, loader) to one-slave Avalon-MM arbiter; grant held until transfer completes.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default gives the loader fixed priority.
module avalon_mem_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  txn_cnt0,
  output logic [CNT_W-1:0]  txn_cnt1,
  output logic              proto_err
);

  arb_state_t       r_state;
  arb_state_t       w_next;
  logic             w_req0;
  logic             w_req1;
  logic             w_done0;
  logic             w_done1;
  logic             w_tie_m1;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;
  logic             r_proto_err;

  assign w_req0  = m0_read | m0_write;
  assign w_req1  = m1_read | m1_write;
  assign w_done0 = (r_state == OWN0) && w_req0 && !s_waitrequest;
  assign w_done1 = (r_state == OWN1) && w_req1 && !s_waitrequest;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last;

  // Tie goes to whichever master did not receive the previous grant.
  assign w_tie_m1 = (r_last == M_CPU);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= M_CPU;
    end else if ((r_state == IDLE) && (w_next != IDLE)) begin
      r_last <= (w_next == OWN1) ? M_LOAD : M_CPU;
    end
  end
`else
  assign w_tie_m1 = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Grant lasts exactly one transfer, or until the owner abandons its request.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) w_next = w_tie_m1 ? OWN1 : OWN0;
        else if (w_req1)      w_next = OWN1;
        else if (w_req0)      w_next = OWN0;
      end
      OWN0:    if (!w_req0 || !s_waitrequest) w_next = IDLE;
      OWN1:    if (!w_req1 || !s_waitrequest) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    m0_waitrequest = w_req0;
    m1_waitrequest = w_req1;
    if (r_state == OWN0) m0_waitrequest = s_waitrequest;
    if (r_state == OWN1) m1_waitrequest = s_waitrequest;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt0      <= '0;
      r_cnt1      <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_done0) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (w_done1) r_cnt1 <= r_cnt1 + CNT_W'(1);
      if ((m0_read && m0_write) || (m1_read && m1_write)) r_proto_err <= 1'b1;
    end
  end

  assign grant       = grant_of(r_state);
  assign txn_cnt0    = r_cnt0;
  assign txn_cnt1    = r_cnt1;
  assign proto_err   = r_proto_err;
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

  avalon_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .i_grant         (grant),
    .i_m0_address    (m0_address),
    .i_m0_read       (m0_read),
    .i_m0_write      (m0_write),
    .i_m0_writedata  (m0_writedata),
    .i_m0_byteenable (m0_byteenable),
    .i_m1_address    (m1_address),
    .i_m1_read       (m1_read),
    .i_m1_write      (m1_write),
    .i_m1_writedata  (m1_writedata),
    .i_m1_byteenable (m1_byteenable),
    .o_address_c     (s_address),
    .o_read_c        (s_read),
    .o_write_c       (s_write),
    .o_writedata_c   (s_writedata),
    .o_byteenable_c  (s_byteenable)
  );

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Bench for avalon_mem_arbiter: transaction-level owner model checked every cycle plus directed literals.
// Honours ARB_ROUND_ROBIN_EN the same way as the design.
module tb_avalon_mem_arbiter;

  localparam int unsigned CW    = 4;
  localparam int          BOUND = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;
  logic [CW-1:0] txn_cnt0, txn_cnt1;
  logic        proto_err;

  int n_vec = 0;
  int n_err = 0;
  int order[$];

  avalon_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(grant), .txn_cnt0(txn_cnt0), .txn_cnt1(txn_cnt1), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the slave (-1 = nobody), completed-transfer counts, sticky error, last winner.
  int m_owner = -1;
  int m_cnt0  = 0;
  int m_cnt1  = 0;
  bit m_perr  = 0;
  int m_last  = 0;

  always @(posedge clk or posedge reset) begin
    bit r0, r1;
    int win;
    if (reset) begin
      m_owner = -1; m_cnt0 = 0; m_cnt1 = 0; m_perr = 0; m_last = 0;
    end else begin
      r0 = m0_read || m0_write;
      r1 = m1_read || m1_write;
      if ((m0_read && m0_write) || (m1_read && m1_write)) m_perr = 1;
      if (m_owner < 0) begin
        win = -1;
`ifdef ARB_ROUND_ROBIN_EN
        if (r0 && r1) win = 1 - m_last;
`else
        if (r0 && r1) win = 1;
`endif
        else if (r1) win = 1;
        else if (r0) win = 0;
        if (win >= 0) begin m_owner = win; m_last = win; end
      end else begin
        if (!(m_owner == 0 ? r0 : r1)) m_owner = -1;
        else if (!s_waitrequest) begin
          if (m_owner == 0) m_cnt0 = (m_cnt0 + 1) % (1 << CW);
          else              m_cnt1 = (m_cnt1 + 1) % (1 << CW);
          m_owner = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("grant", 64'(grant), (m_owner == 0) ? 64'd1 : (m_owner == 1) ? 64'd2 : 64'd0);
    chk("s_read", 64'(s_read), (m_owner == 0) ? 64'(m0_read) : (m_owner == 1) ? 64'(m1_read) : 64'd0);
    chk("s_write", 64'(s_write), (m_owner == 0) ? 64'(m0_write) : (m_owner == 1) ? 64'(m1_write) : 64'd0);
    chk("s_address", 64'(s_address), (m_owner == 0) ? 64'(m0_address) : (m_owner == 1) ? 64'(m1_address) : 64'd0);
    chk("s_writedata", 64'(s_writedata), (m_owner == 0) ? 64'(m0_writedata) : (m_owner == 1) ? 64'(m1_writedata) : 64'd0);
    chk("s_byteenable", 64'(s_byteenable), (m_owner == 0) ? 64'(m0_byteenable) : (m_owner == 1) ? 64'(m1_byteenable) : 64'd0);
    chk("m0_waitrequest", 64'(m0_waitrequest), (m_owner == 0) ? 64'(s_waitrequest) : 64'(m0_read || m0_write));
    chk("m1_waitrequest", 64'(m1_waitrequest), (m_owner == 1) ? 64'(s_waitrequest) : 64'(m1_read || m1_write));
    chk("m0_readdata", 64'(m0_readdata), 64'(s_readdata));
    chk("m1_readdata", 64'(m1_readdata), 64'(s_readdata));
    chk("txn_cnt0", 64'(txn_cnt0), 64'(m_cnt0));
    chk("txn_cnt1", 64'(txn_cnt1), 64'(m_cnt1));
    chk("proto_err", 64'(proto_err), 64'(m_perr));
  end

  task automatic drive(input int m, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  // Avalon master: hold the command for n back-to-back transfers, then release.
  task automatic xfer(input int m, input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input int n, output logic [31:0] rdata);
    rdata = '0;
    drive(m, rd, wr, a, d, 4'hF);
    for (int k = 0; k < n; k++) begin
      bit done = 0;
      int cyc  = 0;
      while (!done && cyc < BOUND) begin
        @(negedge clk);
        if (!((m == 0) ? m0_waitrequest : m1_waitrequest)) begin
          done  = 1;
          rdata = (m == 0) ? m0_readdata : m1_readdata;
        end
        cyc++;
      end
      if (!done) begin
        chk("xfer_timeout", 64'(m), 64'hFFFF);
        break;
      end
      @(posedge clk);
      order.push_back(m);
    end
    #1 drive(m, 0, 0, '0, '0, '0);
  endtask

  task automatic chk_order(input string name, input int exp[$]);
    chk({name, "_len"}, 64'(order.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < order.size(); i++) chk(name, 64'(order[i]), 64'(exp[i]));
  endtask

  initial begin
    logic [31:0] rd0, rd1;
    int exp_a[$];
    int exp_b[$];
    reset = 1'b1;
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    s_waitrequest = 1'b0;
    s_readdata    = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_cnt0", 64'(txn_cnt0), 64'd0);
    chk("rst_perr", 64'(proto_err), 64'd0);

    // Loader writes alone to a zero-wait RAM.
    @(posedge clk); #1;
    fork
      xfer(1, 0, 1, 32'h04, 32'h240ABFC0, 1, rd1);
      begin
        @(posedge clk);
        @(negedge clk);
        chk("t2_s_write", 64'(s_write), 64'd1);
        chk("t2_s_address", 64'(s_address), 64'h04);
        chk("t2_s_writedata", 64'(s_writedata), 64'h240ABFC0);
        chk("t2_m1_wait", 64'(m1_waitrequest), 64'd0);
        chk("t2_grant", 64'(grant), 64'd2);
      end
    join
    @(negedge clk);
    chk("t2_cnt1", 64'(txn_cnt1), 64'd1);

    // Simultaneous single requests.
    order.delete();
    s_readdata = 32'h11112222;
    @(posedge clk); #1;
    fork
      xfer(0, 1, 0, 32'hBFC00000, 32'h0, 1, rd0);
      xfer(1, 0, 1, 32'h08, 32'hCAFE0001, 1, rd1);
    join
`ifdef ARB_ROUND_ROBIN_EN
    exp_a = '{0, 1};
    exp_b = '{0, 1, 0, 1};
`else
    exp_a = '{1, 0};
    exp_b = '{1, 1, 0, 0};
`endif
    chk_order("t3_tie_order", exp_a);

    // Both masters stream two transfers each: every arbitration is a tie while both hold.
    order.delete();
    @(posedge clk); #1;
    fork
      xfer(0, 1, 0, 32'hBFC00000, 32'h0, 2, rd0);
      xfer(1, 0, 1, 32'h08, 32'hCAFE0002, 2, rd1);
    join
    chk_order("t3_stream_order", exp_b);

    // CPU read with a 3-cycle slave stall while the loader waits.
    s_waitrequest = 1'b1;
    s_readdata    = 32'h24020040;
    @(posedge clk); #1;
    fork
      xfer(0, 1, 0, 32'h100, 32'h0, 1, rd0);
      begin
        @(posedge clk); #1;
        xfer(1, 0, 1, 32'h200, 32'h55AA55AA, 1, rd1);
      end
      begin
        @(posedge clk);
        @(negedge clk);
        chk("t4_grant_a", 64'(grant), 64'd1);
        chk("t4_m1_wait_a", 64'(m1_waitrequest), 64'd1);
        @(negedge clk);
        chk("t4_grant_b", 64'(grant), 64'd1);
        chk("t4_m1_wait_b", 64'(m1_waitrequest), 64'd1);
        @(posedge clk); #1 s_waitrequest = 1'b0;
        @(negedge clk);
        chk("t4_grant_c", 64'(grant), 64'd1);
        chk("t4_m1_wait_c", 64'(m1_waitrequest), 64'd1);
      end
    join
    chk("t4_readdata", 64'(rd0), 64'h24020040);

    // CPU asserts read and write together.
    @(posedge clk); #1;
    xfer(0, 1, 1, 32'h300, 32'h77, 1, rd0);
    repeat (2) @(negedge clk);
    chk("t5_perr_sticky", 64'(proto_err), 64'd1);

    // Async reset while the loader owns a stalled slave.
    @(posedge clk); #1;
    s_waitrequest = 1'b1;
    drive(1, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    @(posedge clk);
    @(negedge clk);
    chk("t1_pre_s_write", 64'(s_write), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("t1_s_write", 64'(s_write), 64'd0);
    chk("t1_grant", 64'(grant), 64'd0);
    chk("t1_cnt1", 64'(txn_cnt1), 64'd0);
    chk("t1_perr", 64'(proto_err), 64'd0);
    drive(1, 0, 0, '0, '0, '0);
    s_waitrequest = 1'b0;
    @(posedge clk); #1 reset = 1'b0;

    // Counter wrap: 17 transfers on a 4-bit counter.
    @(posedge clk); #1;
    xfer(0, 1, 0, 32'h40, 32'h0, 17, rd0);
    @(negedge clk);
    chk("t6_cnt0_wrap", 64'(txn_cnt0), 64'd1);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
